// File: rtl/link_list_sram_mp.sv
// Next-pointer store for the cell buffer: P link writers, P chain readers and a
// chain-release walker share one single-access memory behind a class/RR arbiter.
module link_list_sram_mp #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic [NUM_PORTS-1:0]            iWrVld,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] iWrAddr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] iWrData,
    output logic [NUM_PORTS-1:0]            oWrAck,
    input  logic [NUM_PORTS-1:0]            iRdReq,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] iRdAddr,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] oRdData,
    output logic [NUM_PORTS-1:0]            oRdVld,
    input  logic                            iDropVld,
    input  logic [ADDR_WIDTH-1:0]           iDropHead,
    input  logic [ADDR_WIDTH:0]             iDropLen,
    output logic                            oDropRdy,
    output logic [ADDR_WIDTH-1:0]           oFreeAddr,
    output logic                            oFreeVld,
    output logic                            oDropDone
);
    localparam int P     = NUM_PORTS;
    localparam int A     = ADDR_WIDTH;
    localparam int DEPTH = 1 << A;
    localparam int PW    = (P > 1) ? $clog2(P) : 1;

    // walker: IDLE accept | RD read mem[cur] | WAIT free cur | DONE pulse done
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_DONE} walk_state_e;

    logic [A-1:0]  mem_q [DEPTH];
    logic [A-1:0]  mem_rdata_q;
    logic [A-1:0]  rd_hold_q [P];
    logic [P-1:0]  busy_q;
    logic [P-1:0]  rd_vld_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    walk_state_e   state_q, state_d;
    logic [A-1:0]  cur_q, cur_d;
    logic [A:0]    rem_q, rem_d;

    logic [P-1:0]  rd_req;
    logic [P-1:0]  wr_gnt, rd_gnt;
    logic          wr_any, rd_found, rd_any, walk_gnt;
    logic [PW-1:0] wr_win, rd_win;
    logic          mem_we, mem_re;
    logic [A-1:0]  mem_addr, mem_wdata;

    function automatic logic [PW:0] rr_pick(input logic [P-1:0] req, input logic [PW-1:0] ptr);
        logic          found;
        logic [PW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < P; i++) begin
            idx = (int'(ptr) + i) % P;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        return {found, win};
    endfunction

    assign rd_req = iRdReq & ~busy_q;
    assign {wr_any, wr_win}   = rr_pick(iWrVld, wr_ptr_q);
    assign {rd_found, rd_win} = rr_pick(rd_req, rd_ptr_q);
    assign rd_any   = rd_found & ~wr_any;
    assign walk_gnt = (state_q == S_RD) & ~wr_any & ~rd_found;

    always_comb begin
        wr_gnt = '0;
        rd_gnt = '0;
        for (int p = 0; p < P; p++) begin
            wr_gnt[p] = wr_any && (int'(wr_win) == p);
            rd_gnt[p] = rd_any && (int'(rd_win) == p);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_any) wr_ptr_d = PW'((int'(wr_win) + 1) % P);
        if (rd_any) rd_ptr_d = PW'((int'(rd_win) + 1) % P);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = cur_q;
        mem_wdata = '0;
        if (wr_any) begin
            mem_we    = 1'b1;
            mem_addr  = iWrAddr[int'(wr_win)*A +: A];
            mem_wdata = iWrData[int'(wr_win)*A +: A];
        end else if (rd_any) begin
            mem_re   = 1'b1;
            mem_addr = iRdAddr[int'(rd_win)*A +: A];
        end else if (walk_gnt) begin
            mem_re = 1'b1;
        end
    end

    // Storage is deliberately left out of reset so chains survive a reset.
    always_ff @(posedge iClk) begin
        if (mem_we) mem_q[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata_q <= mem_q[mem_addr];
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        oDropRdy  = 1'b0;
        oFreeVld  = 1'b0;
        oFreeAddr = '0;
        oDropDone = 1'b0;
        case (state_q)
            S_IDLE: begin
                oDropRdy = 1'b1;
                if (iDropVld) begin
                    cur_d   = iDropHead;
                    rem_d   = iDropLen;
                    state_d = (iDropLen == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (walk_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                oFreeVld  = 1'b1;
                oFreeAddr = cur_q;
                cur_d     = mem_rdata_q;
                rem_d     = rem_q - (A+1)'(1);
                state_d   = (rem_q == (A+1)'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                oDropDone = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
            rd_vld_q <= '0;
            state_q  <= S_IDLE;
            cur_q    <= '0;
            rem_q    <= '0;
            for (int p = 0; p < P; p++) rd_hold_q[p] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= rd_gnt;
            rd_vld_q <= rd_gnt;
            state_q  <= state_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            for (int p = 0; p < P; p++) begin
                if (rd_vld_q[p]) rd_hold_q[p] <= mem_rdata_q;
            end
        end
    end

    // Shared read register feeds the port in its valid cycle; afterwards the hold copy.
    always_comb begin
        oRdData = '0;
        for (int p = 0; p < P; p++) begin
            oRdData[p*A +: A] = rd_vld_q[p] ? mem_rdata_q : rd_hold_q[p];
        end
    end

    assign oWrAck = wr_gnt;
    assign oRdVld = rd_vld_q;

endmodule

// File: tb/tb_link_list_sram_mp.sv
// Directed bench for link_list_sram_mp: arbitration order, read latency/ordering,
// chain release walks and reset behaviour, with read/free results scoreboarded.
module tb_link_list_sram_mp;
    localparam int P = 4;
    localparam int A = 12;

    logic           iClk = 1'b0;
    logic           iRst = 1'b1;
    logic [P-1:0]   iWrVld = '0;
    logic [P*A-1:0] iWrAddr = '0;
    logic [P*A-1:0] iWrData = '0;
    logic [P-1:0]   oWrAck;
    logic [P-1:0]   iRdReq = '0;
    logic [P*A-1:0] iRdAddr = '0;
    logic [P*A-1:0] oRdData;
    logic [P-1:0]   oRdVld;
    logic           iDropVld = 1'b0;
    logic [A-1:0]   iDropHead = '0;
    logic [A:0]     iDropLen = '0;
    logic           oDropRdy;
    logic [A-1:0]   oFreeAddr;
    logic           oFreeVld;
    logic           oDropDone;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int free_cnt = 0;

    typedef struct {
        int           port;
        logic [A-1:0] data;
    } rd_exp_t;

    rd_exp_t      rd_q[$];
    logic [A-1:0] free_q[$];

    link_list_sram_mp #(.NUM_PORTS(P), .ADDR_WIDTH(A)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iWrVld    (iWrVld),
        .iWrAddr   (iWrAddr),
        .iWrData   (iWrData),
        .oWrAck    (oWrAck),
        .iRdReq    (iRdReq),
        .iRdAddr   (iRdAddr),
        .oRdData   (oRdData),
        .oRdVld    (oRdVld),
        .iDropVld  (iDropVld),
        .iDropHead (iDropHead),
        .iDropLen  (iDropLen),
        .oDropRdy  (oDropRdy),
        .oFreeAddr (oFreeAddr),
        .oFreeVld  (oFreeVld),
        .oDropDone (oDropDone)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [A-1:0] addr, input logic [A-1:0] data);
        iWrAddr[p*A +: A] = addr;
        iWrData[p*A +: A] = data;
    endtask

    // ord holds the expected winner sequence, one port number per nibble
    task automatic wr_burst(input string tag, input logic [P-1:0] mask, input int n,
                            input logic [15:0] ord);
        logic [P-1:0] want;
        iWrVld = mask;
        for (int k = 0; k < n; k++) begin
            #1;
            want = P'(1 << ord[k*4 +: 4]);
            chk($sformatf("%s_ack%0d", tag, k), 32'(oWrAck), 32'(want));
            chk($sformatf("%s_nord%0d", tag, k), 32'(oRdVld), 32'd0);
            cyc();
            iWrVld = iWrVld & ~want;
        end
        iWrVld = '0;
    endtask

    task automatic drop_start(input string tag, input logic [A-1:0] head, input logic [A:0] len);
        chk({tag, "_rdy"}, 32'(oDropRdy), 32'd1);
        iDropVld  = 1'b1;
        iDropHead = head;
        iDropLen  = len;
        cyc();
        iDropVld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (oDropDone !== 1'b1 && k < bound) begin
            cyc();
            k++;
        end
        chk(tag, 32'(oDropDone), 32'd1);
    endtask

    always @(negedge iClk) begin
        rd_exp_t e;
        for (int p = 0; p < P; p++) begin
            if (oRdVld[p]) begin
                chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    chk("rd_port", 32'(p), 32'(e.port));
                    chk("rd_data", 32'(oRdData[p*A +: A]), 32'(e.data));
                end
            end
        end
        if (oFreeVld) begin
            free_cnt++;
            chk("free_expected", 32'(free_q.size() != 0), 32'd1);
            if (free_q.size() != 0) chk("free_addr", 32'(oFreeAddr), 32'(free_q.pop_front()));
        end
        if (oDropDone) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int miss;
        int base;
        int fc;

        // reset state
        #3;
        chk("rst_rdy",    32'(oDropRdy),        32'd1);
        chk("rst_wrack",  32'(oWrAck),          32'd0);
        chk("rst_rdvld",  32'(oRdVld),          32'd0);
        chk("rst_rddata", 32'(oRdData == '0),   32'd1);
        chk("rst_free",   32'(oFreeVld),        32'd0);
        chk("rst_faddr",  32'(oFreeAddr),       32'd0);
        chk("rst_done",   32'(oDropDone),       32'd0);
        cyc();
        iRst = 1'b0;
        cyc();

        // T1: simultaneous writes from reset, then RR resume after the last winner
        for (int p = 0; p < P; p++) set_wr(p, A'(p), A'(16 + p));
        wr_burst("t1a", 4'hF, 4, 16'h3210);
        set_wr(1, 12'd40, 12'd41);
        wr_burst("t1b", 4'b0010, 1, 16'h0001);
        for (int p = 0; p < P; p++) set_wr(p, A'(50 + p), A'(60 + p));
        wr_burst("t1c", 4'hF, 4, 16'h1032);

        // T2: write-then-read ordering and read latency
        set_wr(0, 12'd5, 12'd9);
        wr_burst("t2w", 4'b0001, 1, 16'h0000);
        iRdAddr[2*A +: A] = 12'd5;
        iRdReq[2] = 1'b1;
        rd_q.push_back('{port: 2, data: 12'd9});
        cyc();
        chk("t2_rdvld", 32'(oRdVld), 32'(4'b0100));
        iRdReq[2] = 1'b0;
        cyc();
        chk("t2_pulse", 32'(oRdVld), 32'd0);
        cyc();
        chk("t2_hold", 32'(oRdData[2*A +: A]), 32'd9);

        // T3: writes beat reads; reads then RR starting after port 2
        for (int p = 0; p < P; p++) begin
            set_wr(p, A'(100 + p), A'(200 + p));
            iRdAddr[p*A +: A] = A'(100 + p);
        end
        rd_q.push_back('{port: 3, data: 12'd203});
        rd_q.push_back('{port: 0, data: 12'd200});
        rd_q.push_back('{port: 1, data: 12'd201});
        rd_q.push_back('{port: 2, data: 12'd202});
        iRdReq = 4'hF;
        wr_burst("t3w", 4'hF, 4, 16'h0321);
        chk("t3_no_rd_early", 32'(oRdVld), 32'd0);
        for (int k = 0; k < 4; k++) begin
            logic [P-1:0] want;
            want = P'(1 << ((k + 3) % 4));
            cyc();
            chk($sformatf("t3_rdvld%0d", k), 32'(oRdVld), 32'(want));
            iRdReq = iRdReq & ~want;
        end
        cyc();
        chk("t3_rd_idle", 32'(oRdVld), 32'd0);
        chk("t3_rdq_empty", 32'(rd_q.size()), 32'd0);

        // T4: chain 10->20->30 released; a drop request mid-walk is ignored
        set_wr(3, 12'd10, 12'd20);
        wr_burst("t4a", 4'b1000, 1, 16'h0003);
        set_wr(3, 12'd20, 12'd30);
        wr_burst("t4b", 4'b1000, 1, 16'h0003);
        set_wr(3, 12'd30, 12'd77);
        wr_burst("t4c", 4'b1000, 1, 16'h0003);
        free_q.push_back(12'd10);
        free_q.push_back(12'd20);
        free_q.push_back(12'd30);
        base = done_cnt;
        fc   = free_cnt;
        drop_start("t4", 12'd10, 13'd3);
        chk("t4_busy", 32'(oDropRdy), 32'd0);
        iDropVld  = 1'b1;
        iDropHead = 12'd99;
        iDropLen  = 13'd2;
        cyc();
        iDropVld = 1'b0;
        wait_done("t4_done", 100);
        cyc();
        chk("t4_rdy_back", 32'(oDropRdy), 32'd1);
        cyc();
        chk("t4_done_once", 32'(done_cnt - base), 32'd1);
        chk("t4_free_cnt", 32'(free_cnt - fc), 32'd3);
        chk("t4_freeq_empty", 32'(free_q.size()), 32'd0);
        for (int p = 0; p < P; p++) chk($sformatf("t4_hold%0d", p), 32'(oRdData[p*A +: A]), 32'(200 + p));

        // T5a: zero-length drop
        fc = free_cnt;
        drop_start("t5a", 12'd7, 13'd0);
        chk("t5a_done", 32'(oDropDone), 32'd1);
        chk("t5a_nofree", 32'(oFreeVld), 32'd0);
        cyc();
        chk("t5a_rdy", 32'(oDropRdy), 32'd1);
        chk("t5a_free_cnt", 32'(free_cnt - fc), 32'd0);

        // T5b: full-depth walk on a ring mem[i] = i+1, starting at the all-ones cell
        miss   = 0;
        iWrVld = 4'b0001;
        for (int i = 0; i < 4096; i++) begin
            set_wr(0, A'(i), A'((i + 1) % 4096));
            #1;
            if (oWrAck !== 4'b0001) miss++;
            cyc();
        end
        iWrVld = '0;
        chk("t5b_ring_acks", 32'(miss), 32'd0);
        for (int i = 0; i < 4096; i++) free_q.push_back(A'((4095 + i) % 4096));
        fc   = free_cnt;
        base = done_cnt;
        drop_start("t5b", 12'hFFF, 13'h1000);
        wait_done("t5b_done", 10000);
        cyc();
        chk("t5b_free_cnt", 32'(free_cnt - fc), 32'd4096);
        chk("t5b_freeq_empty", 32'(free_q.size()), 32'd0);
        chk("t5b_done_once", 32'(done_cnt - base), 32'd1);

        // T6: reset mid-walk
        for (int i = 0; i < 4096; i++) free_q.push_back(A'(i));
        fc = free_cnt;
        drop_start("t6", 12'd0, 13'h1000);
        repeat (20) cyc();
        iRst = 1'b1;
        #1;
        chk("t6_free",     32'(oFreeVld),      32'd0);
        chk("t6_faddr",    32'(oFreeAddr),     32'd0);
        chk("t6_rdy",      32'(oDropRdy),      32'd1);
        chk("t6_done",     32'(oDropDone),     32'd0);
        chk("t6_rdvld",    32'(oRdVld),        32'd0);
        chk("t6_rddata",   32'(oRdData == '0), 32'd1);
        chk("t6_progress", 32'(free_cnt > fc), 32'd1);
        free_q.delete();
        base = done_cnt;
        cyc();
        cyc();
        iRst = 1'b0;
        repeat (20) cyc();
        chk("t6_no_done", 32'(done_cnt - base), 32'd0);
        chk("t6_idle_rdy", 32'(oDropRdy), 32'd1);

        // memory survives reset
        iRdAddr[1*A +: A] = 12'd5;
        iRdReq[1] = 1'b1;
        rd_q.push_back('{port: 1, data: 12'd6});
        cyc();
        chk("t6_rd1_vld", 32'(oRdVld), 32'(4'b0010));
        iRdReq[1] = 1'b0;
        iRdAddr[3*A +: A] = 12'hFFF;
        iRdReq[3] = 1'b1;
        rd_q.push_back('{port: 3, data: 12'd0});
        cyc();
        chk("t6_rd3_vld", 32'(oRdVld), 32'(4'b1000));
        iRdReq[3] = 1'b0;
        cyc();
        chk("t6_rdq_empty", 32'(rd_q.size()), 32'd0);

        // RR pointer back at port 0 after reset
        for (int p = 0; p < P; p++) set_wr(p, A'(300 + p), A'(400 + p));
        wr_burst("t6w", 4'hF, 4, 16'h3210);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
